// File: rtl/dtw_seq_ctrl_if.sv
// Register-file, reference-memory and PE signals of the DTW sequencer.
// master: sequencer side; slave: regfile / reference memory / PE side.
interface dtw_seq_ctrl_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int REF_ADDR_W         = 16,
   parameter int REF_W              = 16,
   parameter int COST_W             = 32
);
   logic [C_S_AXI_DATA_WIDTH-1:0] dtw_cr;
   logic [C_S_AXI_DATA_WIDTH-1:0] dtw_ref_len;
   logic [C_S_AXI_DATA_WIDTH-1:0] dtw_sr;
   logic [C_S_AXI_DATA_WIDTH-1:0] dtw_min_val;
   logic [C_S_AXI_DATA_WIDTH-1:0] dtw_pos;
   logic [C_S_AXI_DATA_WIDTH-1:0] dtw_debug0;
   logic [C_S_AXI_DATA_WIDTH-1:0] dtw_debug1;
   logic                          ref_rd_en;
   logic [REF_ADDR_W-1:0]         ref_addr;
   logic [REF_W-1:0]              ref_data;
   logic                          pe_ready;
   logic                          pe_valid;
   logic [REF_W-1:0]              pe_data;
   logic                          pe_last;
   logic                          pe_cost_valid;
   logic [COST_W-1:0]             pe_cost;

   modport master (
      input  dtw_cr, dtw_ref_len, ref_data, pe_ready, pe_cost_valid, pe_cost,
      output dtw_sr, dtw_min_val, dtw_pos, dtw_debug0, dtw_debug1,
             ref_rd_en, ref_addr, pe_valid, pe_data, pe_last
   );

   modport slave (
      output dtw_cr, dtw_ref_len, ref_data, pe_ready, pe_cost_valid, pe_cost,
      input  dtw_sr, dtw_min_val, dtw_pos, dtw_debug0, dtw_debug1,
             ref_rd_en, ref_addr, pe_valid, pe_data, pe_last
   );
endinterface

// File: rtl/dtw_seq_ctrl.sv
// DTW sequencer: reads reference samples, streams them to the PE and tracks the minimum cost.
// Optional drain watchdog is built only when DTW_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a start pulse
// CHECK  | validate the latched length
// STREAM | issue one reference read per cycle with pe_ready
// DRAIN  | all reads issued, collecting remaining costs
// DONE   | publish done, return to IDLE
module dtw_seq_ctrl #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int REF_ADDR_W         = 16,
   parameter int REF_W              = 16,
   parameter int COST_W             = 32,
   parameter int TIMEOUT_CYCLES     = 65535
) (
   input  logic           ACLK,
   input  logic           ARESET,
   dtw_seq_ctrl_if.master bus
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam logic [32:0] MAX_LEN = 33'd1 << REF_ADDR_W;

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [32:0]           len_q, len_d;
   logic [32:0]           issue_cnt_q, issue_cnt_d;
   logic [32:0]           cost_cnt_q, cost_cnt_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic                  len_err_q, len_err_d, timeout_q, timeout_d;
   logic [COST_W-1:0]     min_q, min_d;
   logic [DW-1:0]         pos_q, pos_d;
   logic [15:0]           first_addr_q, first_addr_d, last_addr_q, last_addr_d;
   logic [DW-1:0]         cyc_q, cyc_d;
   logic                  rd_en_q, rd_en_d, rd_last_q, rd_last_d;
   logic [REF_ADDR_W-1:0] addr_q, addr_d;
   logic                  pe_valid_q, pe_valid_d, pe_last_q, pe_last_d;
   logic                  cost_ok;
`ifdef DTW_TIMEOUT_EN
   localparam logic [31:0] WDOG_LOAD = 32'(TIMEOUT_CYCLES);
   logic [31:0]           wdog_q, wdog_d;
`endif

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      issue_cnt_d  = issue_cnt_q;
      cost_cnt_d   = cost_cnt_q;
      busy_d       = busy_q;
      done_d       = done_q;
      len_err_d    = len_err_q;
      timeout_d    = timeout_q;
      min_d        = min_q;
      pos_d        = pos_q;
      first_addr_d = first_addr_q;
      last_addr_d  = last_addr_q;
      rd_en_d      = 1'b0;
      rd_last_d    = 1'b0;
      addr_d       = addr_q;
      pe_valid_d   = rd_en_q;
      pe_last_d    = rd_last_q;
      cyc_d        = cyc_q;
`ifdef DTW_TIMEOUT_EN
      wdog_d       = wdog_q;
`endif
      if (busy_q && (cyc_q != '1))
         cyc_d = cyc_q + DW'(1);

      // Strict compare keeps the earliest index on ties.
      cost_ok = bus.pe_cost_valid &&
                ((state_q == S_CHECK) || (state_q == S_STREAM) || (state_q == S_DRAIN));
      if (cost_ok) begin
         if (bus.pe_cost < min_q) begin
            min_d = bus.pe_cost;
            pos_d = cost_cnt_q[DW-1:0];
         end
         cost_cnt_d = cost_cnt_q + 33'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.dtw_cr[0]) begin
               state_d      = S_CHECK;
               len_d        = 33'(bus.dtw_ref_len);
               busy_d       = 1'b1;
               done_d       = 1'b0;
               len_err_d    = 1'b0;
               timeout_d    = 1'b0;
               min_d        = '1;
               pos_d        = '0;
               cyc_d        = '0;
               issue_cnt_d  = '0;
               cost_cnt_d   = '0;
               first_addr_d = '0;
               last_addr_d  = '0;
            end
         end
         S_CHECK: begin
            if ((len_q == 33'd0) || (len_q > MAX_LEN)) begin
               len_err_d = 1'b1;
               busy_d    = 1'b0;
               state_d   = S_DONE;
            end else begin
               state_d   = S_STREAM;
            end
         end
         S_STREAM: begin
            if (bus.pe_ready) begin
               rd_en_d     = 1'b1;
               addr_d      = issue_cnt_q[REF_ADDR_W-1:0];
               issue_cnt_d = issue_cnt_q + 33'd1;
               last_addr_d = issue_cnt_q[15:0];
               if (issue_cnt_q == 33'd0)
                  first_addr_d = issue_cnt_q[15:0];
               if (issue_cnt_q == (len_q - 33'd1)) begin
                  rd_last_d = 1'b1;
                  state_d   = S_DRAIN;
`ifdef DTW_TIMEOUT_EN
                  wdog_d    = WDOG_LOAD;
`endif
               end
            end
         end
         S_DRAIN: begin
            if (cost_cnt_d >= len_q) begin
               busy_d  = 1'b0;
               state_d = S_DONE;
            end
`ifdef DTW_TIMEOUT_EN
            else if (cost_ok) begin
               wdog_d = WDOG_LOAD;
            end else if (wdog_q <= 32'd1) begin
               timeout_d = 1'b1;
               busy_d    = 1'b0;
               state_d   = S_DONE;
            end else begin
               wdog_d = wdog_q - 32'd1;
            end
`endif
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Soft reset from dtw_cr[1] behaves exactly like ARESET.
   always_ff @(posedge ACLK) begin
      if (ARESET || bus.dtw_cr[1]) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         issue_cnt_q  <= '0;
         cost_cnt_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         len_err_q    <= 1'b0;
         timeout_q    <= 1'b0;
         min_q        <= '1;
         pos_q        <= '0;
         first_addr_q <= '0;
         last_addr_q  <= '0;
         cyc_q        <= '0;
         rd_en_q      <= 1'b0;
         rd_last_q    <= 1'b0;
         addr_q       <= '0;
         pe_valid_q   <= 1'b0;
         pe_last_q    <= 1'b0;
`ifdef DTW_TIMEOUT_EN
         wdog_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         issue_cnt_q  <= issue_cnt_d;
         cost_cnt_q   <= cost_cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         len_err_q    <= len_err_d;
         timeout_q    <= timeout_d;
         min_q        <= min_d;
         pos_q        <= pos_d;
         first_addr_q <= first_addr_d;
         last_addr_q  <= last_addr_d;
         cyc_q        <= cyc_d;
         rd_en_q      <= rd_en_d;
         rd_last_q    <= rd_last_d;
         addr_q       <= addr_d;
         pe_valid_q   <= pe_valid_d;
         pe_last_q    <= pe_last_d;
`ifdef DTW_TIMEOUT_EN
         wdog_q       <= wdog_d;
`endif
      end
   end

   assign bus.dtw_sr      = {{(DW-4){1'b0}}, timeout_q, len_err_q, done_q, busy_q};
   assign bus.dtw_min_val = DW'(min_q);
   assign bus.dtw_pos     = pos_q;
   assign bus.dtw_debug0  = DW'({first_addr_q, last_addr_q});
   assign bus.dtw_debug1  = cyc_q;
   assign bus.ref_rd_en   = rd_en_q;
   assign bus.ref_addr    = addr_q;
   assign bus.pe_valid    = pe_valid_q;
   assign bus.pe_last     = pe_last_q;
   // Memory read data is already registered and lines up with pe_valid.
   assign bus.pe_data     = bus.ref_data;
endmodule

// File: tb/tb_dtw_seq_ctrl.sv
// Scoreboard bench for dtw_seq_ctrl: expected reads/samples queued at start, popped as the DUT emits them.
module tb_dtw_seq_ctrl;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int RW = 16;
   localparam int CW = 32;
`ifdef DTW_TIMEOUT_EN
   localparam int TO_CYC = 16;
`else
   localparam int TO_CYC = 65535;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_pass = 0;
   int   exp_addr[$];
   logic [RW-1:0] exp_data[$];
   int   cost_tab[16];
   logic [31:0] exp_min;
   int   exp_pos;

   dtw_seq_ctrl_if #(.C_S_AXI_DATA_WIDTH(DW), .REF_ADDR_W(AW), .REF_W(RW), .COST_W(CW)) bus ();

   dtw_seq_ctrl #(
      .C_S_AXI_DATA_WIDTH(DW), .REF_ADDR_W(AW), .REF_W(RW), .COST_W(CW), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .ACLK  (clk),
      .ARESET(rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [RW-1:0] sample_of(input int a);
      return RW'(a * 37 + 5);
   endfunction

   // Reference memory: data one cycle after the read strobe.
   always @(posedge clk)
      if (bus.ref_rd_en) bus.ref_data <= sample_of(int'(bus.ref_addr));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input int len, input int ncost, input bit toggle_rdy,
                          input int mid_start, input int budget, output bit got_done);
      int cyc, reads, samples, given, pend, last_edge;
      bit fed_now;
      exp_addr.delete();
      exp_data.delete();
      for (int i = 0; i < len; i++) begin
         exp_addr.push_back(i);
         exp_data.push_back(sample_of(i));
      end
      exp_min = 32'hFFFF_FFFF;
      exp_pos = 0;
      for (int i = 0; i < ncost; i++)
         if (32'(cost_tab[i]) < exp_min) begin
            exp_min = 32'(cost_tab[i]);
            exp_pos = i;
         end
      got_done = 1'b0;
      cyc = 0; reads = 0; samples = 0; given = 0; pend = 0; last_edge = -1;
      bus.dtw_ref_len = 32'(len);
      bus.dtw_cr = 32'h1;
      tick();
      bus.dtw_cr = 32'h0;
      while (!got_done && cyc < budget) begin
         bus.pe_ready = toggle_rdy ? (cyc % 2 == 0) : 1'b1;
         bus.dtw_cr = (cyc == mid_start) ? 32'h1 : 32'h0;
         if (cyc == mid_start) bus.dtw_ref_len = 32'(len + 3);
         fed_now = 1'b0;
         if (pend > 0 && given < ncost) begin
            bus.pe_cost_valid = 1'b1;
            bus.pe_cost = 32'(cost_tab[given]);
            given++;
            pend--;
            fed_now = 1'b1;
         end else begin
            bus.pe_cost_valid = 1'b0;
         end
         tick();
         cyc++;
         if (fed_now && given == len) last_edge = cyc;
         if (bus.ref_rd_en) begin
            reads++;
            n_chk++;
            if (exp_addr.size() == 0) begin
               $display("FAIL rd_addr: unexpected read at addr %0d, expected no read", bus.ref_addr);
            end else begin
               int e;
               e = exp_addr.pop_front();
               if (int'(bus.ref_addr) !== e)
                  $display("FAIL rd_addr: got %0d, expected %0d", bus.ref_addr, e);
               else n_pass++;
            end
         end
         if (bus.pe_valid) begin
            n_chk++;
            if (exp_data.size() == 0) begin
               $display("FAIL pe_sample: unexpected sample 0x%0h, expected none", bus.pe_data);
            end else begin
               logic [RW-1:0] ed;
               ed = exp_data.pop_front();
               if (bus.pe_data !== ed || bus.pe_last !== (samples == len - 1))
                  $display("FAIL pe_sample: got data 0x%0h last %0b, expected data 0x%0h last %0b",
                           bus.pe_data, bus.pe_last, ed, (samples == len - 1));
               else n_pass++;
            end
            samples++;
            pend++;
         end
         if (bus.dtw_sr[1]) got_done = 1'b1;
      end
      bus.pe_cost_valid = 1'b0;
      bus.pe_ready = 1'b1;
      bus.dtw_cr = 32'h0;
      n_chk++;
      if (reads !== len) $display("FAIL read_count: got %0d, expected %0d", reads, len);
      else n_pass++;
      if (got_done && ncost == len) begin
         n_chk++;
         if (cyc - last_edge !== 1)
            $display("FAIL done_latency: done %0d cycles after last cost, expected 1", cyc - last_edge);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.dtw_cr = '0; bus.dtw_ref_len = '0; bus.pe_ready = 1'b1;
      bus.pe_cost_valid = 1'b0; bus.pe_cost = '0;
      repeat (3) tick();
      n_chk++; if (bus.dtw_sr !== 32'h0) $display("FAIL rst_sr: got 0x%0h, expected 0x0", bus.dtw_sr); else n_pass++;
      n_chk++; if (bus.dtw_min_val !== 32'hFFFF_FFFF) $display("FAIL rst_min: got 0x%0h, expected 0xffffffff", bus.dtw_min_val); else n_pass++;
      n_chk++; if (bus.dtw_pos !== 32'h0) $display("FAIL rst_pos: got %0d, expected 0", bus.dtw_pos); else n_pass++;
      n_chk++; if (bus.dtw_debug0 !== 32'h0 || bus.dtw_debug1 !== 32'h0)
         $display("FAIL rst_debug: got 0x%0h/0x%0h, expected 0/0", bus.dtw_debug0, bus.dtw_debug1); else n_pass++;
      n_chk++; if ({bus.ref_rd_en, bus.pe_valid, bus.pe_last} !== 3'b000)
         $display("FAIL rst_strobes: got %b, expected 000", {bus.ref_rd_en, bus.pe_valid, bus.pe_last}); else n_pass++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      bit gd;
      cost_tab[0] = 9; cost_tab[1] = 3; cost_tab[2] = 7; cost_tab[3] = 3;
      run_job(4, 4, 1'b0, -1, 60, gd);
      n_chk++; if (gd !== 1'b1 || bus.dtw_sr !== 32'h2) $display("FAIL basic_sr: got 0x%0h, expected 0x2", bus.dtw_sr); else n_pass++;
      n_chk++; if (bus.dtw_min_val !== exp_min) $display("FAIL basic_min: got %0d, expected %0d", bus.dtw_min_val, exp_min); else n_pass++;
      n_chk++; if (bus.dtw_pos !== 32'(exp_pos)) $display("FAIL basic_pos: got %0d, expected %0d", bus.dtw_pos, exp_pos); else n_pass++;
      n_chk++; if (bus.dtw_debug0 !== 32'h0000_0003) $display("FAIL basic_debug0: got 0x%0h, expected 0x3", bus.dtw_debug0); else n_pass++;
      n_chk++; if (bus.dtw_debug1 !== 32'd7) $display("FAIL basic_debug1: got %0d, expected 7", bus.dtw_debug1); else n_pass++;
      repeat (2) tick();
   endtask

   task automatic test_len_err();
      bit saw_rd;
      saw_rd = 1'b0;
      bus.dtw_ref_len = 32'd0;
      bus.dtw_cr = 32'h1;
      tick();
      bus.dtw_cr = 32'h0;
      saw_rd |= bus.ref_rd_en;
      n_chk++; if (bus.dtw_sr !== 32'h1) $display("FAIL len0_busy: got 0x%0h, expected 0x1", bus.dtw_sr); else n_pass++;
      tick();
      saw_rd |= bus.ref_rd_en;
      n_chk++; if (bus.dtw_sr !== 32'h4) $display("FAIL len0_sr: got 0x%0h, expected 0x4", bus.dtw_sr); else n_pass++;
      n_chk++; if (bus.dtw_min_val !== 32'hFFFF_FFFF) $display("FAIL len0_min: got 0x%0h, expected 0xffffffff", bus.dtw_min_val); else n_pass++;
      repeat (3) begin tick(); saw_rd |= bus.ref_rd_en; end
      n_chk++; if (saw_rd !== 1'b0) $display("FAIL len0_rd: got read strobe %0b, expected 0", saw_rd); else n_pass++;
      bus.dtw_ref_len = 32'h0001_0001;
      bus.dtw_cr = 32'h1;
      tick();
      bus.dtw_cr = 32'h0;
      repeat (3) begin tick(); saw_rd |= bus.ref_rd_en; end
      n_chk++; if (bus.dtw_sr[2] !== 1'b1 || saw_rd !== 1'b0)
         $display("FAIL len_big: got sr 0x%0h rd %0b, expected err set and no read", bus.dtw_sr, saw_rd); else n_pass++;
   endtask

   task automatic test_ready_toggle();
      bit gd;
      cost_tab[0] = 4; cost_tab[1] = 6; cost_tab[2] = 2;
      run_job(3, 3, 1'b1, -1, 80, gd);
      n_chk++; if (gd !== 1'b1 || bus.dtw_sr !== 32'h2) $display("FAIL toggle_sr: got 0x%0h, expected 0x2", bus.dtw_sr); else n_pass++;
      n_chk++; if (bus.dtw_debug0 !== 32'h0000_0002) $display("FAIL toggle_debug0: got 0x%0h, expected 0x2", bus.dtw_debug0); else n_pass++;
      n_chk++; if (bus.dtw_min_val !== exp_min || bus.dtw_pos !== 32'(exp_pos))
         $display("FAIL toggle_min: got %0d@%0d, expected %0d@%0d", bus.dtw_min_val, bus.dtw_pos, exp_min, exp_pos); else n_pass++;
      repeat (2) tick();
   endtask

   task automatic test_abort();
      bit gd;
      bus.dtw_ref_len = 32'd8;
      bus.pe_ready = 1'b1;
      bus.dtw_cr = 32'h1;
      tick();
      bus.dtw_cr = 32'h0;
      repeat (3) tick();
      n_chk++; if (bus.ref_rd_en !== 1'b1) $display("FAIL abort_pre: rd_en %0b, expected 1", bus.ref_rd_en); else n_pass++;
      bus.dtw_cr = 32'h2;
      tick();
      n_chk++; if (bus.dtw_sr !== 32'h0 || bus.ref_rd_en !== 1'b0)
         $display("FAIL abort_sr: got sr 0x%0h rd %0b, expected 0x0 0", bus.dtw_sr, bus.ref_rd_en); else n_pass++;
      n_chk++; if (bus.dtw_min_val !== 32'hFFFF_FFFF || bus.dtw_debug1 !== 32'h0)
         $display("FAIL abort_regs: got min 0x%0h dbg1 %0d, expected 0xffffffff 0", bus.dtw_min_val, bus.dtw_debug1); else n_pass++;
      bus.dtw_cr = 32'h3;
      tick();
      n_chk++; if (bus.dtw_sr !== 32'h0) $display("FAIL abort_prio: got 0x%0h, expected 0x0", bus.dtw_sr); else n_pass++;
      bus.dtw_cr = 32'h0;
      tick();
      cost_tab[0] = 5; cost_tab[1] = 4;
      run_job(2, 2, 1'b0, -1, 40, gd);
      n_chk++; if (gd !== 1'b1 || bus.dtw_min_val !== 32'd4 || bus.dtw_pos !== 32'd1)
         $display("FAIL restart: got done %0b min %0d pos %0d, expected 1 4 1", gd, bus.dtw_min_val, bus.dtw_pos); else n_pass++;
      repeat (2) tick();
   endtask

   task automatic test_back_to_back();
      bit gd;
      cost_tab[0] = 8; cost_tab[1] = 8; cost_tab[2] = 2;
      cost_tab[3] = 9; cost_tab[4] = 2; cost_tab[5] = 1;
      run_job(6, 6, 1'b0, 3, 80, gd);
      n_chk++; if (gd !== 1'b1 || bus.dtw_sr !== 32'h2) $display("FAIL b2b_sr: got 0x%0h, expected 0x2", bus.dtw_sr); else n_pass++;
      n_chk++; if (bus.dtw_min_val !== exp_min || bus.dtw_pos !== 32'(exp_pos))
         $display("FAIL b2b_min: got %0d@%0d, expected %0d@%0d", bus.dtw_min_val, bus.dtw_pos, exp_min, exp_pos); else n_pass++;
      n_chk++; if (bus.dtw_debug0 !== 32'h0000_0005) $display("FAIL b2b_debug0: got 0x%0h, expected 0x5", bus.dtw_debug0); else n_pass++;
      cost_tab[0] = 11; cost_tab[1] = 12;
      run_job(2, 2, 1'b0, -1, 40, gd);
      n_chk++; if (gd !== 1'b1 || bus.dtw_min_val !== 32'd11 || bus.dtw_pos !== 32'd0)
         $display("FAIL b2b_second: got done %0b min %0d pos %0d, expected 1 11 0", gd, bus.dtw_min_val, bus.dtw_pos); else n_pass++;
      repeat (2) tick();
   endtask

   task automatic test_drain_wait();
      bit gd;
      cost_tab[0] = 7;
      run_job(2, 1, 1'b0, -1, 60, gd);
`ifdef DTW_TIMEOUT_EN
      n_chk++; if (gd !== 1'b1 || bus.dtw_sr !== 32'hA) $display("FAIL timeout_sr: got 0x%0h, expected 0xa", bus.dtw_sr); else n_pass++;
      n_chk++; if (bus.dtw_min_val !== 32'd7 || bus.dtw_pos !== 32'd0)
         $display("FAIL timeout_min: got %0d@%0d, expected 7@0", bus.dtw_min_val, bus.dtw_pos); else n_pass++;
`else
      n_chk++; if (gd !== 1'b0 || bus.dtw_sr !== 32'h1) $display("FAIL drain_wait: got 0x%0h, expected 0x1", bus.dtw_sr); else n_pass++;
      bus.dtw_cr = 32'h2;
      tick();
      bus.dtw_cr = 32'h0;
      n_chk++; if (bus.dtw_sr !== 32'h0) $display("FAIL drain_abort: got 0x%0h, expected 0x0", bus.dtw_sr); else n_pass++;
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_err();
      test_ready_toggle();
      test_abort();
      test_back_to_back();
      test_drain_wait();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, expected finish earlier", $time);
      $fatal(1);
   end
endmodule
